// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the register RAW hazard logic: write-select codes,
// the load opcode, and the pending-write entry layout.
package pipe_hazard_pkg;
  localparam logic [1:0] WSEL_RT   = 2'b00;
  localparam logic [1:0] WSEL_RD   = 2'b01;
  localparam logic [1:0] WSEL_RS   = 2'b10;
  localparam logic [1:0] WSEL_R7   = 2'b11;
  localparam logic [2:0] RET_REG   = 3'h7;
  localparam logic [4:0] LD_OPCODE = 5'b10001;
  localparam int         REG_W     = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     wr;
    reg_idx_t rd;
    logic     is_load;
  } pwt_entry_t;
endpackage

// File: rtl/dest_reg_decode.sv
// Destination-register and load-class decode of an instruction word.
// Used by both the pending-write tracker and the stall detector.
module dest_reg_decode #(
  parameter logic [2:0] RET_REG = pipe_hazard_pkg::RET_REG
) (
  input  logic [15:0] instr_i,
  input  logic [1:0]  wsel_i,
  output logic [2:0]  reg_o,
  output logic        is_load_o
);
  import pipe_hazard_pkg::*;

  always_comb begin
    case (wsel_i)
      WSEL_RT: reg_o = instr_i[7:5];
      WSEL_RD: reg_o = instr_i[4:2];
      WSEL_RS: reg_o = instr_i[10:8];
      default: reg_o = RET_REG;
    endcase
  end

  assign is_load_o = (instr_i[15:11] == LD_OPCODE);

  // Low encoding bits never name a destination.
  logic unused_bits;
  assign unused_bits = ^instr_i[1:0];
endmodule

// File: rtl/pending_write_tracker.sv
// In-order scoreboard of register writes still owed by in-flight instructions.
// Pushes at decode exit, pops at writeback, and answers a fetch-stage busy query.
module pending_write_tracker #(
  parameter int         DEPTH   = 4,
  parameter int         PTR_W   = 2,
  parameter logic [2:0] RET_REG = pipe_hazard_pkg::RET_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [15:0]      issue_instr,
  input  logic [1:0]       issue_wsel,
  input  logic             issue_regwrite,
  output logic             issue_ready,
  input  logic             retire_valid,
  input  logic [2:0]       retire_reg,
  input  logic             retire_regwrite,
  input  logic             flush_valid,
  input  logic [PTR_W-1:0] flush_cnt,
  input  logic [2:0]       query_reg,
  output logic             query_busy,
  output logic             query_load_busy,
  output logic [PTR_W:0]   occupancy,
  output logic             err
);
  import pipe_hazard_pkg::*;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  pwt_entry_t       ent_q [DEPTH];
  pwt_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d, cnt_pop;
  logic [PTR_W-1:0] n_flush, push_idx;
  logic             err_q, err_d;
  logic             push, pop, hd_mismatch;
  reg_idx_t         dec_reg;
  logic             dec_load;

  dest_reg_decode #(.RET_REG(RET_REG)) u_dec (
    .instr_i   (issue_instr),
    .wsel_i    (issue_wsel),
    .reg_o     (dec_reg),
    .is_load_o (dec_load)
  );

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign issue_ready = (count_q != FULL) | retire_valid;
  assign push        = issue_valid & issue_ready;
  assign pop         = retire_valid & (count_q != '0);
  assign cnt_pop     = count_q - (PTR_W+1)'(pop);
  assign n_flush     = !flush_valid                  ? '0        :
                       ({1'b0, flush_cnt} <= cnt_pop) ? flush_cnt : cnt_pop[PTR_W-1:0];
  assign push_idx    = tail_q - n_flush;
  assign hd_mismatch = (ent_q[head_q].wr != retire_regwrite) |
                       (ent_q[head_q].wr & (ent_q[head_q].rd != retire_reg));

  // Order matters: pop, then flush of the youngest, then the new push.
  always_comb begin
    ent_d = ent_q;
    if (pop) ent_d[head_q].valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < {1'b0, n_flush})
        ent_d[tail_q - PTR_W'(i) - PTR_W'(1)].valid = 1'b0;
    end
    if (push)
      ent_d[push_idx] = '{valid: 1'b1, wr: issue_regwrite, rd: dec_reg, is_load: dec_load};
  end

  assign head_d  = head_q + PTR_W'(pop);
  assign tail_d  = push_idx + PTR_W'(push);
  assign count_d = cnt_pop - {1'b0, n_flush} + (PTR_W+1)'(push);
  assign err_d   = err_q | (issue_valid & ~issue_ready) |
                   (retire_valid & (count_q == '0)) | (pop & hd_mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      ent_q   <= ent_d;
    end
  end

  // Registered entries only: a same-cycle issue shows up next cycle.
  always_comb begin
    query_busy      = 1'b0;
    query_load_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].wr && (ent_q[i].rd == query_reg)) begin
        query_busy = 1'b1;
        if (ent_q[i].is_load) query_load_busy = 1'b1;
      end
    end
  end

  assign occupancy = count_q;
  assign err       = err_q;
endmodule

// File: tb/tb_pending_write_tracker.sv
// Vector-table bench for pending_write_tracker: each row drives one cycle and
// states the outputs expected during that cycle, before its clock edge.
module tb_pending_write_tracker;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_regwrite, issue_ready;
  logic [15:0] issue_instr;
  logic [1:0]  issue_wsel;
  logic        retire_valid, retire_regwrite;
  logic [2:0]  retire_reg;
  logic        flush_valid;
  logic [1:0]  flush_cnt;
  logic [2:0]  query_reg;
  logic        query_busy, query_load_busy, err;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_write_tracker #(.DEPTH(4), .PTR_W(2), .RET_REG(3'h7)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_instr     (issue_instr),
    .issue_wsel      (issue_wsel),
    .issue_regwrite  (issue_regwrite),
    .issue_ready     (issue_ready),
    .retire_valid    (retire_valid),
    .retire_reg      (retire_reg),
    .retire_regwrite (retire_regwrite),
    .flush_valid     (flush_valid),
    .flush_cnt       (flush_cnt),
    .query_reg       (query_reg),
    .query_busy      (query_busy),
    .query_load_busy (query_load_busy),
    .occupancy       (occupancy),
    .err             (err)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] ins;
    logic [1:0]  ws;
    logic        rw;
    logic        rv;
    logic [2:0]  rr;
    logic        rrw;
    logic        fv;
    logic [1:0]  fc;
    logic [2:0]  q;
    logic        e_rdy;
    logic        e_busy;
    logic        e_lbusy;
    logic [2:0]  e_occ;
    logic        e_err;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t v(logic rs, logic iv, logic [15:0] ins, logic [1:0] ws, logic rw,
                             logic rv, logic [2:0] rr, logic rrw, logic fv, logic [1:0] fc,
                             logic [2:0] q, logic er, logic eb, logic elb, logic [2:0] eo,
                             logic ee);
    vec_t t;
    t.rst = rs; t.iv = iv; t.ins = ins; t.ws = ws; t.rw = rw;
    t.rv = rv; t.rr = rr; t.rrw = rrw; t.fv = fv; t.fc = fc; t.q = q;
    t.e_rdy = er; t.e_busy = eb; t.e_lbusy = elb; t.e_occ = eo; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, required %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    @(negedge clk);
    rst = t.rst; issue_valid = t.iv; issue_instr = t.ins; issue_wsel = t.ws;
    issue_regwrite = t.rw; retire_valid = t.rv; retire_reg = t.rr;
    retire_regwrite = t.rrw; flush_valid = t.fv; flush_cnt = t.fc; query_reg = t.q;
    exp_q.push_back(t);
    #1;
    e = exp_q.pop_front();
    chk("issue_ready", idx, {7'd0, issue_ready}, {7'd0, e.e_rdy});
    chk("query_busy", idx, {7'd0, query_busy}, {7'd0, e.e_busy});
    chk("query_load_busy", idx, {7'd0, query_load_busy}, {7'd0, e.e_lbusy});
    chk("occupancy", idx, {5'd0, occupancy}, {5'd0, e.e_occ});
    chk("err", idx, {7'd0, err}, {7'd0, e.e_err});
  endtask

  initial begin
    rst = 1'b1; issue_valid = 0; issue_instr = '0; issue_wsel = '0; issue_regwrite = 0;
    retire_valid = 0; retire_reg = '0; retire_regwrite = 0; flush_valid = 0;
    flush_cnt = '0; query_reg = '0;

    //            rs iv ins       ws rw rv rr rrw fv fc q   rdy busy lb occ err
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 16'h8860, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 3, 1, 0, 0, 3, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
    // fill with R1..R4, then issue R5 while retiring R1 at full
    tbl.push_back(v(0, 1, 16'h0020, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 16'h0060, 0, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 1, 16'h0080, 0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 4, 0));
    tbl.push_back(v(0, 1, 16'h00A0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 2, 1, 0, 0, 2, 1, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 3, 1, 0, 0, 3, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 4, 1, 0, 0, 4, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
    // R1,R2,R6 then drop the two youngest
    tbl.push_back(v(0, 1, 16'h0020, 0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 16'h00C0, 0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 2, 6, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush + push same edge: push lands at the rewound tail
    tbl.push_back(v(0, 1, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 16'h0060, 0, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 16'h0080, 0, 1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 2, 0));
    // retire + oversized flush: clamped to what survives the pop
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 2, 1, 1, 3, 4, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0));
    // wsel 11/10/01, a non-writer, then a mismatched retire
    tbl.push_back(v(0, 1, 16'h0000, 3, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 16'h8A00, 2, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 16'h0014, 1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1, 2, 0));
    tbl.push_back(v(0, 1, 16'h00E0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 5, 0, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 5, 1, 0, 0, 7, 1, 1, 0, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 3, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 2, 1, 0, 0, 2, 1, 1, 1, 3, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 5, 1, 0, 0, 5, 1, 1, 0, 2, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset clears err; retire on empty sets it without moving state
    apply(v(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 100);
    apply(v(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 101);
    apply(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 102);
    apply(v(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 103);
    // fill, issue while full (rejected), then reset alongside issue/retire/flush
    apply(v(0, 1, 16'h0020, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 104);
    apply(v(0, 1, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0), 105);
    apply(v(0, 1, 16'h0060, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0), 106);
    apply(v(0, 1, 16'h0080, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 3, 0), 107);
    apply(v(0, 1, 16'h00A0, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 4, 0), 108);
    apply(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 4, 1), 109);
    apply(v(1, 1, 16'h00C0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 4, 1), 110);
    apply(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 111);
    apply(v(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0), 112);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
